// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 serial receiver that rebuilds 32-bit words from four
// consecutive bytes (first byte lands in the most significant position).
// It also reports stop-bit framing errors and drops a partial word when the
// link goes quiet for too long between bytes.
module uart_word_rx #(
  parameter int CLK_DIV     = 327,
  parameter int OVERSAMPLE  = 16,
  parameter int GAP_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_tick,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        word_abort
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int S_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [S_W-1:0]   S_HALF   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser and tick generator
  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             rx_s;
  logic             tick;

  // Frame FSM
  state_t           state_q, state_d;
  logic [S_W-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             accept;
  logic             ferr_set;
  logic             start_det;

  // Word assembly, gap timer and outputs
  logic [31:0]      word_shift_q, word_shift_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             word_done_q, word_done_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_tick_q, rx_byte_tick_d;
  logic [31:0]      word_data_q, word_data_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             word_abort_q, word_abort_d;

  assign rx_s = sync_q[1];
  assign tick = (div_cnt_q == DIV_LAST);

  // Two-stage synchroniser on rx and the free-running oversample divider
  always_comb begin
    sync_d    = {sync_q[0], rx};
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Frame FSM: start-bit qualification, LSB-first data sampling, stop check
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    accept    = 1'b0;
    ferr_set  = 1'b0;
    start_det = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          s_cnt_d   = '0;
          start_det = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            if (!rx_s) begin
              state_d   = S_DATA;
              s_cnt_d   = '0;
              bit_cnt_d = '0;
            end else begin
              // Too short to be a start bit: treat as a glitch
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            shreg_d   = {rx_s, shreg_q[7:1]};
            s_cnt_d   = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (rx_s) begin
              accept  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start is looked for
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte/word assembly, inter-byte gap timer and output pulses
  always_comb begin
    rx_byte_d      = rx_byte_q;
    rx_byte_tick_d = 1'b0;
    word_shift_d   = word_shift_q;
    byte_idx_d     = byte_idx_q;
    word_done_d    = 1'b0;
    word_data_d    = word_data_q;
    word_valid_d   = 1'b0;
    frame_err_d    = ferr_set;
    word_abort_d   = 1'b0;
    gap_cnt_d      = gap_cnt_q;

    // Word is published the cycle after its last byte is published
    if (word_done_q) begin
      word_data_d  = word_shift_q;
      word_valid_d = 1'b1;
    end

    if (accept) begin
      rx_byte_d      = shreg_q;
      rx_byte_tick_d = 1'b1;
      word_shift_d   = {word_shift_q[23:0], shreg_q};
      byte_idx_d     = byte_idx_q + 2'd1;
      word_done_d    = (byte_idx_q == 2'd3);
      gap_cnt_d      = '0;
    end else if (ferr_set) begin
      // A bad frame discards any partial word silently
      byte_idx_d = '0;
      gap_cnt_d  = '0;
    end else if (byte_idx_q == 2'd0) begin
      gap_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if (gap_cnt_q == GAP_LAST) begin
        // A start bit arriving on the timeout cycle keeps the word alive
        if (!start_det) begin
          byte_idx_d   = '0;
          gap_cnt_d    = '0;
          word_abort_d = 1'b1;
        end
      end else begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
    end
  end

  // State register; reset returns every flop to its idle value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= 2'b11;
      div_cnt_q      <= '0;
      state_q        <= S_IDLE;
      s_cnt_q        <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      word_shift_q   <= '0;
      byte_idx_q     <= '0;
      word_done_q    <= 1'b0;
      gap_cnt_q      <= '0;
      rx_byte_q      <= '0;
      rx_byte_tick_q <= 1'b0;
      word_data_q    <= '0;
      word_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      word_abort_q   <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      div_cnt_q      <= div_cnt_d;
      state_q        <= state_d;
      s_cnt_q        <= s_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      word_shift_q   <= word_shift_d;
      byte_idx_q     <= byte_idx_d;
      word_done_q    <= word_done_d;
      gap_cnt_q      <= gap_cnt_d;
      rx_byte_q      <= rx_byte_d;
      rx_byte_tick_q <= rx_byte_tick_d;
      word_data_q    <= word_data_d;
      word_valid_q   <= word_valid_d;
      frame_err_q    <= frame_err_d;
      word_abort_q   <= word_abort_d;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_byte_tick = rx_byte_tick_q;
  assign word_data    = word_data_q;
  assign word_valid   = word_valid_q;
  assign frame_err    = frame_err_q;
  assign word_abort   = word_abort_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx: drives serial frames on rx and compares the
// received bytes, words and fault pulses against expectations built here.
module tb_uart_word_rx;

  localparam int CLK_DIV = 4;
  localparam int OVS     = 16;
  localparam int GAP     = 1000;
  localparam int BIT     = CLK_DIV * OVS;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  rx_byte;
  logic        rx_byte_tick;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        word_abort;

  uart_word_rx #(
    .CLK_DIV(CLK_DIV),
    .OVERSAMPLE(OVS),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_byte(rx_byte),
    .rx_byte_tick(rx_byte_tick),
    .word_data(word_data),
    .word_valid(word_valid),
    .frame_err(frame_err),
    .word_abort(word_abort)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed events, written only by the monitor
  logic [7:0]  got_bytes[$];
  logic [31:0] got_words[$];
  int          n_ferr    = 0;
  int          n_abort   = 0;
  int          n_wv_late = 0;
  logic        prev_tick = 1'b0;

  // Reference model state, written only by the stimulus process
  logic [7:0]  pend[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  int          exp_ferr;
  int          exp_abort;
  int          bb, bw, bf, ba, bl;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    int          exp_nw;
    logic [31:0] exp_word;
    int          exp_abort;
  } vec_t;

  vec_t tbl[6];

  // Monitor: sample outputs mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_byte_tick) got_bytes.push_back(rx_byte);
      if (word_valid) begin
        got_words.push_back(word_data);
        if (!prev_tick) n_wv_late <= n_wv_late + 1;
      end
      if (frame_err)  n_ferr  <= n_ferr + 1;
      if (word_abort) n_abort <= n_abort + 1;
    end
    prev_tick <= rx_byte_tick;
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the model records what a correct receiver must report
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop_ok, BIT);
    if (stop_ok) begin
      exp_bytes.push_back(b);
      pend.push_back(b);
      if (pend.size() == 4) begin
        exp_words.push_back({pend[0], pend[1], pend[2], pend[3]});
        pend.delete();
      end
    end else begin
      exp_ferr++;
      pend.delete();
    end
  endtask

  // Idle line; the gap runs from mid stop bit, so half a bit is added
  task automatic idle(input int n);
    hold(1'b1, n);
    if (pend.size() > 0 && n + BIT / 2 > GAP) begin
      exp_abort++;
      pend.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst rx_byte", 32'(rx_byte), 32'h0);
    chk("rst rx_byte_tick", 32'(rx_byte_tick), 32'h0);
    chk("rst word_data", word_data, 32'h0);
    chk("rst word_valid", 32'(word_valid), 32'h0);
    chk("rst frame_err", 32'(frame_err), 32'h0);
    chk("rst word_abort", 32'(word_abort), 32'h0);
    reset = 1'b0;
    pend.delete();
    hold(1'b1, 8);
  endtask

  task automatic begin_scn();
    bb = got_bytes.size();
    bw = got_words.size();
    bf = n_ferr;
    ba = n_abort;
    bl = n_wv_late;
    exp_bytes.delete();
    exp_words.delete();
    exp_ferr  = 0;
    exp_abort = 0;
  endtask

  task automatic end_scn(input string name);
    int nb, nw;
    nb = got_bytes.size() - bb;
    nw = got_words.size() - bw;
    chk({name, " byte count"}, 32'(nb), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < nb; i++)
      chk($sformatf("%s byte[%0d]", name, i), 32'(got_bytes[bb + i]), 32'(exp_bytes[i]));
    chk({name, " word count"}, 32'(nw), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < nw; i++)
      chk($sformatf("%s word[%0d]", name, i), got_words[bw + i], exp_words[i]);
    chk({name, " frame_err count"}, 32'(n_ferr - bf), 32'(exp_ferr));
    chk({name, " word_abort count"}, 32'(n_abort - ba), 32'(exp_abort));
    chk({name, " word_valid latency"}, 32'(n_wv_late - bl), 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    int         sel, gap, nb, nw;

    reset = 1'b1;
    rx    = 1'b1;
    tbl[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 0,         1, 32'hDEADBEEF, 0};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 0,         1, 32'h00000000, 0};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 0,         1, 32'hFFFFFFFF, 0};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 200,       1, 32'h80017FFE, 0};
    tbl[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 0,         1, 32'hA55AC33C, 0};
    tbl[5] = '{8'h12, 8'h34, 8'h56, 8'h78, GAP + 150, 0, 32'h0,        4};

    // Table-driven words
    do_reset();
    for (int v = 0; v < 6; v++) begin
      begin_scn();
      send_frame(tbl[v].b0, 1'b1); if (tbl[v].gap > 0) idle(tbl[v].gap);
      send_frame(tbl[v].b1, 1'b1); if (tbl[v].gap > 0) idle(tbl[v].gap);
      send_frame(tbl[v].b2, 1'b1); if (tbl[v].gap > 0) idle(tbl[v].gap);
      send_frame(tbl[v].b3, 1'b1); if (tbl[v].gap > 0) idle(tbl[v].gap);
      idle(2 * BIT);
      nb = got_bytes.size() - bb;
      nw = got_words.size() - bw;
      chk($sformatf("tbl%0d byte count", v), 32'(nb), 32'd4);
      if (nb == 4) begin
        chk($sformatf("tbl%0d b0", v), 32'(got_bytes[bb]),     32'(tbl[v].b0));
        chk($sformatf("tbl%0d b3", v), 32'(got_bytes[bb + 3]), 32'(tbl[v].b3));
      end
      chk($sformatf("tbl%0d word count", v), 32'(nw), 32'(tbl[v].exp_nw));
      if (tbl[v].exp_nw == 1 && nw == 1)
        chk($sformatf("tbl%0d word", v), got_words[bw], tbl[v].exp_word);
      chk($sformatf("tbl%0d aborts", v), 32'(n_abort - ba), 32'(tbl[v].exp_abort));
      chk($sformatf("tbl%0d frame_err", v), 32'(n_ferr - bf), 32'h0);
    end

    // Short low glitch is ignored, then a normal byte still gets through
    do_reset();
    begin_scn();
    hold(1'b0, 3 * CLK_DIV);
    hold(1'b1, 2 * BIT);
    end_scn("glitch");
    begin_scn();
    send_frame(8'h3C, 1'b1);
    idle(2 * BIT);
    end_scn("after glitch");

    // Bad stop bit mid-word, then a clean word
    do_reset();
    begin_scn();
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    send_frame(8'h55, 1'b0);
    idle(16);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    idle(2 * BIT);
    end_scn("framing");
    if (got_words.size() > 0) chk("framing last word", got_words[$], 32'h01020304);

    // Gap timeout drops a partial word
    do_reset();
    begin_scn();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(GAP + 10);
    send_frame(8'hCA, 1'b1);
    send_frame(8'hFE, 1'b1);
    send_frame(8'hBA, 1'b1);
    send_frame(8'hBE, 1'b1);
    idle(2 * BIT);
    end_scn("timeout");
    if (got_words.size() > 0) chk("timeout last word", got_words[$], 32'hCAFEBABE);

    // Reset in the middle of the third byte's data bits
    begin_scn();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT / 2);
    #3;
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset rx_byte", 32'(rx_byte), 32'h0);
    chk("midreset word_data", word_data, 32'h0);
    chk("midreset rx_byte_tick", 32'(rx_byte_tick), 32'h0);
    reset = 1'b0;
    pend.delete();
    hold(1'b1, 8);
    end_scn("pre reset");
    begin_scn();
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h01, 1'b1);
    idle(2 * BIT);
    end_scn("post reset");
    if (got_words.size() > 0) chk("post reset word", got_words[$], 32'h00000001);

    // Eight back-to-back bytes, then a long break
    do_reset();
    begin_scn();
    for (int i = 0; i < 8; i++) begin
      b = 8'(8'h11 * (i + 1));
      send_frame(b, 1'b1);
    end
    idle(2 * BIT);
    hold(1'b0, 20 * BIT);
    hold(1'b1, 2 * BIT);
    exp_ferr++;
    pend.delete();
    end_scn("b2b+break");

    // Randomized frames and gaps against the model
    do_reset();
    begin_scn();
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       gap = 0;
        1:       gap = $urandom_range(8, 300);
        2:       gap = $urandom_range(GAP + 100, GAP + 300);
        default: gap = $urandom_range(8, 64);
      endcase
      if (!ok && gap < 8) gap = 8;
      send_frame(b, ok);
      if (gap > 0) idle(gap);
    end
    idle(2 * BIT);
    end_scn("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
